// File: rtl/game_timer_ctrl.sv
// Countdown game timer: a prescaler turns clk cycles into game seconds, and a
// four-state FSM handles start/pause/restart. The displayed value is latched per video frame.
module game_timer_ctrl #(
    parameter int TICKS_PER_SEC = 25000000,
    parameter int START_VALUE   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       restart,
    input  logic       frame_start,
    output logic [6:0] game_duration,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       second_tick,
    output logic       expire_pulse
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    START_CNT = 7'(START_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    game_duration_q, game_duration_d;
    logic          second_tick_q, second_tick_d;
    logic          expire_pulse_q, expire_pulse_d;
    logic          running_q, paused_q, expired_q;
    logic          wrap;

    assign wrap = (state_q == ST_RUNNING) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        presc_d         = presc_q;
        second_tick_d   = 1'b0;
        expire_pulse_d  = 1'b0;
        game_duration_d = frame_start ? count_q : game_duration_q;

        // Free-running second counting; requests below may override it.
        if (state_q == ST_RUNNING) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (wrap && count_q != 7'd0) begin
                second_tick_d = 1'b1;
                count_d       = count_q - 7'd1;
                if (count_q == 7'd1) begin
                    state_d        = ST_EXPIRED;
                    expire_pulse_d = 1'b1;
                end
            end
        end

        if (restart) begin
            state_d        = ST_IDLE;
            count_d        = START_CNT;
            presc_d        = '0;
            second_tick_d  = 1'b0;
            expire_pulse_d = 1'b0;
        end else if (start) begin
            if (state_q == ST_IDLE || state_q == ST_EXPIRED) begin
                state_d = ST_RUNNING;
                count_d = START_CNT;
                presc_d = '0;
            end
        end else if (pause_toggle) begin
            // An expiry on the same cycle takes precedence over pausing.
            if (state_q == ST_RUNNING && state_d != ST_EXPIRED)
                state_d = ST_PAUSED;
            else if (state_q == ST_PAUSED)
                state_d = ST_RUNNING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            count_q         <= START_CNT;
            presc_q         <= '0;
            game_duration_q <= START_CNT;
            second_tick_q   <= 1'b0;
            expire_pulse_q  <= 1'b0;
            running_q       <= 1'b0;
            paused_q        <= 1'b0;
            expired_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            presc_q         <= presc_d;
            game_duration_q <= game_duration_d;
            second_tick_q   <= second_tick_d;
            expire_pulse_q  <= expire_pulse_d;
            running_q       <= (state_d == ST_RUNNING);
            paused_q        <= (state_d == ST_PAUSED);
            expired_q       <= (state_d == ST_EXPIRED);
        end
    end

    assign game_duration = game_duration_q;
    assign running       = running_q;
    assign paused        = paused_q;
    assign expired       = expired_q;
    assign second_tick   = second_tick_q;
    assign expire_pulse  = expire_pulse_q;

endmodule
